// File: rtl/minitb_ahb_pkg.sv
// Shared definitions for the mini AHB slave: transfer-type encodings and the
// slave FSM state type.
package minitb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DATA = 2'b10
    } slave_state_e;

    // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are no-ops.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage : minitb_ahb_pkg

// File: rtl/minitb_ahb_slave_if.sv
// AHB-style bus bundle between one master and the mini slave.
interface minitb_ahb_slave_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
);
    logic [1:0]           htrans;
    logic [addrWidth-1:0] haddr;
    logic                 hwrite;
    logic [dataWidth-1:0] hwdata;
    logic [dataWidth-1:0] hrdata;
    logic                 hready;

    modport master (
        output htrans, haddr, hwrite, hwdata,
        input  hrdata, hready
    );

    modport slave (
        input  htrans, haddr, hwrite, hwdata,
        output hrdata, hready
    );
endinterface : minitb_ahb_slave_if

// File: rtl/minitb_ahb_slave_ram.sv
// Single-port word array: synchronous write, combinational read.
module minitb_ahb_slave_ram #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [addrWidth-1:0] addr_i,
    input  logic [dataWidth-1:0] wdata_i,
    output logic [dataWidth-1:0] rdata_o
);
    logic [dataWidth-1:0] mem_q [2**addrWidth];

    // NOTE: the array has no reset; its contents must survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : minitb_ahb_slave_ram

// File: rtl/minitb_ahb_slave.sv
// Mini AHB memory slave: registered address phase, WAIT_STATES hready-low
// cycles per transfer, read data held between read data phases.
module minitb_ahb_slave
    import minitb_ahb_pkg::*;
#(
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    minitb_ahb_slave_if.slave bus
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    slave_state_e         state_q, state_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [dataWidth-1:0] hrdata_q, hrdata_d;
    logic [dataWidth-1:0] ram_rdata;
    logic                 hready;
    logic                 accept;
    logic                 ram_we;
    logic                 rd_phase;

    assign accept = hready && trans_active(bus.htrans);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            cnt_q    <= 4'd0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            hrdata_q <= hrdata_d;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new address phase can only land in IDLE or DATA, where hready=1.
        if (accept) begin
            addr_d  = bus.haddr;
            write_d = bus.hwrite;
            cnt_d   = WAIT_LOAD;
            state_d = (WAIT_LOAD == 4'd0) ? ST_DATA : ST_WAIT;
        end
    end

    // Reads come straight from the array during DATA, so a read following a
    // write to the same word sees the value committed at the write's last edge.
    always_comb begin
        hready   = (state_q != ST_WAIT);
        ram_we   = (state_q == ST_DATA) && write_q;
        rd_phase = (state_q == ST_DATA) && !write_q;
        hrdata_d = rd_phase ? ram_rdata : hrdata_q;
    end

    assign bus.hready = hready;
    assign bus.hrdata = hrdata_d;

    minitb_ahb_slave_ram #(
        .addrWidth (addrWidth),
        .dataWidth (dataWidth)
    ) u_ram (
        .clk_i   (hclk),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (bus.hwdata),
        .rdata_o (ram_rdata)
    );

endmodule : minitb_ahb_slave

// File: tb/tb_minitb_ahb_slave.sv
// Scoreboard bench: three slaves with 0, 2 and 3 wait states driven by a
// pipelined master; read data predicted from a bench-side memory model.
module tb_minitb_ahb_slave;
    import minitb_ahb_pkg::*;

    typedef struct packed {
        logic [1:0]  trans;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } op_t;

    logic             hclk;
    logic             hreset;
    logic [2:0][1:0]  htrans_v;
    logic [2:0][7:0]  haddr_v;
    logic [2:0]       hwrite_v;
    logic [2:0][31:0] hwdata_v;
    logic [2:0]       hready_w;
    logic [2:0][31:0] hrdata_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    op_t         ops[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [3][256];
    logic [31:0] last_read [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        minitb_ahb_slave_if #(.addrWidth(8), .dataWidth(32)) bus ();
        assign bus.htrans  = htrans_v[g];
        assign bus.haddr   = haddr_v[g];
        assign bus.hwrite  = hwrite_v[g];
        assign bus.hwdata  = hwdata_v[g];
        assign hready_w[g] = bus.hready;
        assign hrdata_w[g] = bus.hrdata;

        minitb_ahb_slave #(
            .addrWidth   (8),
            .dataWidth   (32),
            .WAIT_STATES (WS)
        ) u_dut (
            .hclk   (hclk),
            .hreset (hreset),
            .bus    (bus)
        );
    end

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int sel);
        return (sel == 0) ? 0 : ((sel == 1) ? 2 : 3);
    endfunction

    task automatic add_op(input logic [1:0] trans, input logic wr,
                          input logic [7:0] addr, input logic [31:0] data);
        op_t o;
        o.trans = trans;
        o.wr    = wr;
        o.addr  = addr;
        o.data  = data;
        ops.push_back(o);
    endtask

    // Pipelined master: entered and left at 1 time unit after a rising edge.
    task automatic run_ops(input int sel, input bit scramble);
        op_t         pend;
        op_t         cur;
        bit          pend_v = 1'b0;
        bit          driven;
        int          lows   = 0;
        int          guard  = 0;
        logic        rdy;
        logic [31:0] exp;
        pend = '0;
        while ((ops.size() > 0 || pend_v) && guard < 500) begin
            guard++;
            rdy    = hready_w[sel];
            driven = 1'b0;
            if (!rdy && scramble) begin
                htrans_v[sel] = guard[0] ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr_v[sel]  = 8'h51;
                hwrite_v[sel] = 1'b1;
            end else if (ops.size() > 0) begin
                cur           = ops[0];
                htrans_v[sel] = cur.trans;
                haddr_v[sel]  = cur.addr;
                hwrite_v[sel] = cur.wr;
                driven        = rdy;
            end else begin
                htrans_v[sel] = HTRANS_IDLE;
            end
            hwdata_v[sel] = (pend_v && pend.wr) ? pend.data : 32'hBADBAD00;

            if (!pend_v) check($sformatf("idle_hready_d%0d", sel), {31'd0, rdy}, 32'd1);
            if (!rdy) lows++;
            if (pend_v && rdy) begin
                check($sformatf("wait_cycles_d%0d", sel), lows, ws_of(sel));
                if (pend.wr) begin
                    model_mem[sel][pend.addr] = pend.data;
                end else if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    exp = exp_q.pop_front();
                    check($sformatf("rdata_d%0d_a%h", sel, pend.addr), hrdata_w[sel], exp);
                    last_read[sel] = exp;
                end
            end

            @(posedge hclk);
            #1;
            if (rdy) begin
                pend_v = 1'b0;
                if (driven) begin
                    cur = ops.pop_front();
                    if (cur.trans == HTRANS_NONSEQ || cur.trans == HTRANS_SEQ) begin
                        pend   = cur;
                        pend_v = 1'b1;
                        lows   = 0;
                        if (!cur.wr) exp_q.push_back(model_mem[sel][cur.addr]);
                    end
                end
            end
        end
        if (guard >= 500) begin
            check("timeout", 32'd0, 32'd1);
            ops.delete();
        end
        htrans_v[sel] = HTRANS_IDLE;
        hwrite_v[sel] = 1'b0;
    endtask

    task automatic idle_hold(input int sel, input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
        check($sformatf("hrdata_hold_d%0d", sel), hrdata_w[sel], last_read[sel]);
    endtask

    initial begin
        htrans_v = '0;
        haddr_v  = '0;
        hwrite_v = '0;
        hwdata_v = '0;
        hreset   = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_hready_d%0d", i), {31'd0, hready_w[i]}, 32'd1);
            check($sformatf("reset_hrdata_d%0d", i), hrdata_w[i], 32'd0);
        end
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // Zero wait states: write/read, back-to-back forwarding, BUSY no-op.
        add_op(HTRANS_NONSEQ, 1'b1, 8'h0A, 32'hDEADBEEF);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h0A, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b1, 8'h20, 32'h00000001);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h20, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b1, 8'h40, 32'h00000055);
        add_op(HTRANS_BUSY,   1'b1, 8'h40, 32'h000000FF);
        add_op(HTRANS_IDLE,   1'b1, 8'h40, 32'h000000FF);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h40, 32'h0);
        add_op(HTRANS_SEQ,    1'b0, 8'h0A, 32'h0);
        run_ops(0, 1'b0);
        idle_hold(0, 3);

        // Two wait states: preload then read, plus back-to-back write/read.
        add_op(HTRANS_NONSEQ, 1'b1, 8'h10, 32'h12345678);
        add_op(HTRANS_NONSEQ, 1'b1, 8'h30, 32'h00000000);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h10, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b1, 8'h20, 32'h00000001);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h20, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h10, 32'h0);
        run_ops(1, 1'b0);
        idle_hold(1, 2);

        // Three wait states with the address bus scrambled while hready is low.
        add_op(HTRANS_NONSEQ, 1'b1, 8'h51, 32'h11111111);
        add_op(HTRANS_NONSEQ, 1'b1, 8'h50, 32'hCAFEF00D);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h50, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h51, 32'h0);
        run_ops(2, 1'b1);
        idle_hold(2, 2);

        // Reset during the WAIT of a write must abort it.
        htrans_v[1] = HTRANS_NONSEQ;
        hwrite_v[1] = 1'b1;
        haddr_v[1]  = 8'h30;
        @(posedge hclk);
        #1;
        check("rst_pre_wait_hready", {31'd0, hready_w[1]}, 32'd0);
        htrans_v[1] = HTRANS_IDLE;
        hwrite_v[1] = 1'b0;
        hwdata_v[1] = 32'h000000FF;
        hreset      = 1'b1;
        #1;
        check("rst_hready", {31'd0, hready_w[1]}, 32'd1);
        check("rst_hrdata", hrdata_w[1], 32'd0);
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(posedge hclk);
        #1;
        add_op(HTRANS_NONSEQ, 1'b0, 8'h30, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b0, 8'h10, 32'h0);
        run_ops(1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_minitb_ahb_slave

// File: doc/minitb_ahb_slave.md
MINITB_AHB_SLAVE -- requirements
Module: minitb_ahb_slave

Interface
REQ-001 SHALL have parameter addrWidth, default 8, address width; memory depth is 2**addrWidth words, haddr is a word index.
REQ-002 SHALL have parameter dataWidth, default 32, data bus width.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..15; number of hready-low cycles inserted per transfer.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: hclk and hreset.
REQ-005 hclk  input  1  bus clock; all sampling on rising edge.
REQ-006 hreset  input  1  asynchronous, active-high reset.
REQ-007 htrans  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 haddr  input  addrWidth  address-phase word address.
REQ-009 hwrite  input  1  address-phase direction; 1 = write.
REQ-010 hwdata  input  dataWidth  write data, valid in the data phase.
REQ-011 hrdata  output  dataWidth  read data, valid in the data phase when hready=1.
REQ-012 hready  output  1  1 = current data phase completes this cycle.

Function
REQ-013 SHALL accept an address phase at a rising hclk edge where hready=1 and htrans is NONSEQ or SEQ; BUSY and IDLE SHALL be treated as no transfer.
REQ-014 SHALL register haddr and hwrite on acceptance and enter the data phase on the next cycle.
REQ-015 SHALL implement FSM states IDLE, WAIT and DATA: IDLE->WAIT on acceptance when WAIT_STATES>0, IDLE->DATA on acceptance when WAIT_STATES=0; WAIT->DATA when the wait counter reaches zero; DATA->WAIT, DATA->DATA or DATA->IDLE depending on whether a new address phase is accepted in the same cycle.
REQ-016 SHALL drive hready=0 while in WAIT, and hready=1 in IDLE and DATA.
REQ-017 SHALL load a 4-bit wait counter with WAIT_STATES on acceptance and decrement it once per WAIT cycle.
REQ-018 Write: SHALL store hwdata to the registered address at the rising edge that ends the data phase (hready=1).
REQ-019 Read: SHALL drive mem[registered address] on hrdata throughout the DATA state; zero-wait latency is one cycle from the address phase.
REQ-020 When hready=0, SHALL ignore any htrans, haddr or hwrite presented, and no new address phase SHALL be accepted.
REQ-021 Pipelining: an address phase accepted during a write data phase SHALL be honoured back-to-back with no idle cycle.
REQ-022 Read-after-write hazard: a read whose address phase coincides with a write data phase to the same address SHALL return the newly written data (forwarded).
REQ-023 hrdata SHALL hold its previous value outside read data phases.

Reset
REQ-024 On hreset=1, SHALL immediately set state=IDLE, hready=1, hrdata=0 and wait counter=0, and clear the registered address/direction.
REQ-025 An assertion of hreset mid-transfer SHALL abort the transfer; a pending write SHALL NOT be committed.
REQ-026 Memory contents SHALL NOT be affected by hreset.

Structure
REQ-027 Package minitb_ahb_pkg SHALL hold the htrans constants (IDLE, BUSY, NONSEQ, SEQ) and the slave FSM state enum.
REQ-028 Storage SHALL be a sub-module, minitb_ahb_slave_ram: a single-port array with synchronous write and combinational read, parameterised by addrWidth and dataWidth.

Verification
REQ-029 WAIT_STATES=0: write 0x0A <- 0xDEADBEEF, then read 0x0A -> hrdata=0xDEADBEEF one cycle after the read address phase, with hready held at 1 throughout.
REQ-030 WAIT_STATES=2: read 0x10 (preloaded 0x12345678) -> hready low for exactly 2 cycles, then high with hrdata=0x12345678.
REQ-031 Back-to-back write 0x20 <- 0x1 immediately followed by read 0x20 -> read returns 0x1 (forwarding), with no idle cycle between the transfers.
REQ-032 WAIT_STATES=3: change haddr/htrans while hready=0 -> the changes are ignored and the original transfer completes unaltered.
REQ-033 Assert hreset during WAIT of write 0x30 <- 0xFF (0x30 previously 0x0) -> hready=1 and hrdata=0 immediately; a later read of 0x30 returns 0x0.
REQ-034 htrans=BUSY with hwrite=1 at 0x40 -> no write occurs (0x40 unchanged) and hready stays 1.
